// File: rtl/l2cache_pkg.sv
// ---------------------------------------------------------------------------
// l2cache_pkg
// Shared definitions for the L2 cache L1-side arbiter.
//   - Source codes carried on l2_from, telling the L2 who issued a request
//     and whether a Dcache access is a read or a write.
//   - State encoding of the arbiter FSM.
// No ports (package).
// ---------------------------------------------------------------------------
package l2cache_pkg;

  localparam logic [1:0] FROM_NONE = 2'd0;
  localparam logic [1:0] FROM_I    = 2'd1;
  localparam logic [1:0] FROM_DR   = 2'd2;
  localparam logic [1:0] FROM_DW   = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_DATA = 2'd2
  } arb_state_e;

endpackage

// File: rtl/l2cache_arb_prio.sv
// ---------------------------------------------------------------------------
// l2cache_arb_prio
// Grant decision between the Icache and the Dcache, plus the starvation
// counter that guarantees the Icache eventually wins against a Dcache that
// keeps requesting.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   grant_en_i      arbiter is in IDLE and may grant this cycle
//   icache_req_i    Icache request
//   dcache_req_i    Dcache request
//   grant_valid_o   a grant happens this cycle
//   grant_icache_o  the grant (if any) goes to the Icache; else the Dcache
// ---------------------------------------------------------------------------
module l2cache_arb_prio
  import l2cache_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic grant_en_i,
  input  logic icache_req_i,
  input  logic dcache_req_i,
  output logic grant_valid_o,
  output logic grant_icache_o
);

  localparam int CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

  logic [CntW-1:0] starve_cnt_q;
  logic [CntW-1:0] starve_cnt_d;

  assign grant_valid_o  = grant_en_i & (icache_req_i | dcache_req_i);
  // Dcache normally wins; a starved Icache overrides it.
  assign grant_icache_o = icache_req_i & ((starve_cnt_q == Limit) | ~dcache_req_i);

  // Only Dcache grants that overtake a waiting Icache count as starvation;
  // every other grant resets the count.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (grant_valid_o) begin
      if (!grant_icache_o && icache_req_i) begin
        starve_cnt_d = (starve_cnt_q == Limit) ? starve_cnt_q : starve_cnt_q + 1'b1;
      end else begin
        starve_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/l2cache_l1_arbiter.sv
// ---------------------------------------------------------------------------
// l2cache_l1_arbiter
// Shares the single L1-facing request port of the L2 cache between the Icache
// and the Dcache. One transaction outstanding at a time: the granted request
// is latched, presented to the L2 until accepted, and the L2 handshakes and
// line data are routed back to the owner only.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   icache_req/addr               Icache read request (held until addrOK)
//   icache_addrOK/dataOK/dout     Icache handshakes and returned line
//   dcache_req/wr/addr/din/wstrb  Dcache request (held until addrOK)
//   dcache_addrOK/dataOK/dout     Dcache handshakes and returned line
//   l2_req/from/addr/din/wstrb    latched request towards the L2
//   l2_addrOK/dataOK/dout         L2 handshakes and line data
//   arb_busy                      a transaction is in flight
//   arb_timeout                   sticky: WAIT_DATA lasted TIMEOUT cycles
// ---------------------------------------------------------------------------
module l2cache_l1_arbiter
  import l2cache_pkg::*;
#(
  parameter int L1offset_width = 2,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT        = 1023
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                icache_req,
  input  logic [31:0]                         icache_addr,
  output logic                                icache_addrOK,
  output logic                                icache_dataOK,
  output logic [32*(1<<L1offset_width)-1:0]   icache_dout,
  input  logic                                dcache_req,
  input  logic                                dcache_wr,
  input  logic [31:0]                         dcache_addr,
  input  logic [31:0]                         dcache_din,
  input  logic [3:0]                          dcache_wstrb,
  output logic                                dcache_addrOK,
  output logic                                dcache_dataOK,
  output logic [32*(1<<L1offset_width)-1:0]   dcache_dout,
  output logic                                l2_req,
  output logic [1:0]                          l2_from,
  output logic [31:0]                         l2_addr,
  output logic [31:0]                         l2_din,
  output logic [3:0]                          l2_wstrb,
  input  logic                                l2_addrOK,
  input  logic                                l2_dataOK,
  input  logic [32*(1<<L1offset_width)-1:0]   l2_dout,
  output logic                                arb_busy,
  output logic                                arb_timeout
);

  localparam int WdW = $clog2(TIMEOUT + 1);
  localparam logic [WdW-1:0] WdLimit = WdW'(TIMEOUT);

  arb_state_e     state_q;
  logic [1:0]     owner_q;
  logic [31:0]    addr_q;
  logic [31:0]    din_q;
  logic [3:0]     wstrb_q;
  logic           l2_req_q;
  logic [WdW-1:0] wd_cnt_q;
  logic [WdW-1:0] wd_cnt_d;
  logic           timeout_q;

  logic grant_valid;
  logic grant_icache;
  logic owner_is_i;
  logic owner_is_d;

  l2cache_arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .clk           (clk),
    .rst           (rst),
    .grant_en_i    (state_q == IDLE),
    .icache_req_i  (icache_req),
    .dcache_req_i  (dcache_req),
    .grant_valid_o (grant_valid),
    .grant_icache_o(grant_icache)
  );

  assign owner_is_i = (owner_q == FROM_I);
  assign owner_is_d = owner_q[1];

  // Handshakes are combinational so the owner sees them in the same cycle as
  // the L2; stray L2 handshakes in the wrong state are masked here.
  assign icache_addrOK = (state_q == REQ) & l2_addrOK & owner_is_i;
  assign dcache_addrOK = (state_q == REQ) & l2_addrOK & owner_is_d;
  assign icache_dataOK = (state_q != IDLE) & l2_dataOK & owner_is_i;
  assign dcache_dataOK = (state_q != IDLE) & l2_dataOK & owner_is_d;
  assign icache_dout   = ((state_q != IDLE) && owner_is_i) ? l2_dout : '0;
  assign dcache_dout   = ((state_q != IDLE) && owner_is_d) ? l2_dout : '0;

  assign l2_req      = l2_req_q;
  assign l2_from     = owner_q;
  assign l2_addr     = addr_q;
  assign l2_din      = din_q;
  assign l2_wstrb    = wstrb_q;
  assign arb_busy    = (state_q != IDLE);
  assign arb_timeout = timeout_q;

  // Watchdog: counts cycles spent waiting for data, saturating at the limit,
  // and restarts from zero every time WAIT_DATA is left.
  always_comb begin
    wd_cnt_d = '0;
    if (state_q == WAIT_DATA && !l2_dataOK) begin
      wd_cnt_d = (wd_cnt_q == WdLimit) ? wd_cnt_q : wd_cnt_q + 1'b1;
    end
  end

  // Arbiter FSM. The request fields are captured once at grant and left
  // untouched until the transaction returns to IDLE, so a requester changing
  // its inputs mid-flight cannot corrupt what the L2 sees.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= FROM_NONE;
      addr_q    <= '0;
      din_q     <= '0;
      wstrb_q   <= '0;
      l2_req_q  <= 1'b0;
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant_valid) begin
            state_q  <= REQ;
            l2_req_q <= 1'b1;
            if (grant_icache) begin
              owner_q <= FROM_I;
              addr_q  <= icache_addr;
              din_q   <= '0;
              wstrb_q <= '0;
            end else begin
              owner_q <= dcache_wr ? FROM_DW : FROM_DR;
              addr_q  <= dcache_addr;
              din_q   <= dcache_wr ? dcache_din : '0;
              wstrb_q <= dcache_wr ? dcache_wstrb : 4'b0000;
            end
          end
        end
        REQ: begin
          if (l2_addrOK) begin
            l2_req_q <= 1'b0;
            state_q  <= l2_dataOK ? IDLE : WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (l2_dataOK) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q  <= IDLE;
          l2_req_q <= 1'b0;
        end
      endcase
      wd_cnt_q <= wd_cnt_d;
      if (wd_cnt_d == WdLimit) begin
        timeout_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_l2cache_l1_arbiter.sv
// ---------------------------------------------------------------------------
// tb_l2cache_l1_arbiter
// Directed bench for the L2 L1-side arbiter. Inputs are driven on the falling
// edge and outputs are sampled on the falling edge (plus #1 for outputs that
// react combinationally to inputs driven on that same edge).
// ---------------------------------------------------------------------------
module tb_l2cache_l1_arbiter;

  localparam int L1W = 2;
  localparam int DW  = 32 * (1 << L1W);

  logic          clk = 1'b0;
  logic          rst;
  logic          icache_req;
  logic [31:0]   icache_addr;
  logic          icache_addrOK;
  logic          icache_dataOK;
  logic [DW-1:0] icache_dout;
  logic          dcache_req;
  logic          dcache_wr;
  logic [31:0]   dcache_addr;
  logic [31:0]   dcache_din;
  logic [3:0]    dcache_wstrb;
  logic          dcache_addrOK;
  logic          dcache_dataOK;
  logic [DW-1:0] dcache_dout;
  logic          l2_req;
  logic [1:0]    l2_from;
  logic [31:0]   l2_addr;
  logic [31:0]   l2_din;
  logic [3:0]    l2_wstrb;
  logic          l2_addrOK;
  logic          l2_dataOK;
  logic [DW-1:0] l2_dout;
  logic          arb_busy;
  logic          arb_timeout;

  int compared   = 0;
  int mismatched = 0;

  l2cache_l1_arbiter #(
    .L1offset_width(L1W),
    .STARVE_LIMIT  (4),
    .TIMEOUT       (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .icache_req   (icache_req),
    .icache_addr  (icache_addr),
    .icache_addrOK(icache_addrOK),
    .icache_dataOK(icache_dataOK),
    .icache_dout  (icache_dout),
    .dcache_req   (dcache_req),
    .dcache_wr    (dcache_wr),
    .dcache_addr  (dcache_addr),
    .dcache_din   (dcache_din),
    .dcache_wstrb (dcache_wstrb),
    .dcache_addrOK(dcache_addrOK),
    .dcache_dataOK(dcache_dataOK),
    .dcache_dout  (dcache_dout),
    .l2_req       (l2_req),
    .l2_from      (l2_from),
    .l2_addr      (l2_addr),
    .l2_din       (l2_din),
    .l2_wstrb     (l2_wstrb),
    .l2_addrOK    (l2_addrOK),
    .l2_dataOK    (l2_dataOK),
    .l2_dout      (l2_dout),
    .arb_busy     (arb_busy),
    .arb_timeout  (arb_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  // Power-on reset: every output must read zero.
  task automatic test_reset();
    rst = 1'b1;
    icache_req = 0; icache_addr = '0;
    dcache_req = 0; dcache_wr = 0; dcache_addr = '0; dcache_din = '0; dcache_wstrb = '0;
    l2_addrOK = 0; l2_dataOK = 0; l2_dout = '0;
    tick();
    compared++; if (l2_req !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_l2_req: got %0h expected 0", l2_req); end
    compared++; if (l2_from !== 2'd0) begin mismatched++; $display("[TB] FAIL rst_l2_from: got %0h expected 0", l2_from); end
    compared++; if (l2_addr !== 32'h0) begin mismatched++; $display("[TB] FAIL rst_l2_addr: got %0h expected 0", l2_addr); end
    compared++; if (arb_busy !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_busy: got %0h expected 0", arb_busy); end
    compared++; if (arb_timeout !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_timeout: got %0h expected 0", arb_timeout); end
    rst = 1'b0;
    tick();
  endtask

  // Single Icache read, addrOK and dataOK in separate cycles.
  task automatic test_lone_icache();
    logic [DW-1:0] pat;
    pat = {4{32'hA5A5_A5A5}};
    icache_req = 1; icache_addr = 32'h1000_0040;
    tick();
    compared++; if (l2_req !== 1'b1) begin mismatched++; $display("[TB] FAIL lone_l2_req: got %0h expected 1", l2_req); end
    compared++; if (l2_from !== 2'd1) begin mismatched++; $display("[TB] FAIL lone_l2_from: got %0h expected 1", l2_from); end
    compared++; if (l2_addr !== 32'h1000_0040) begin mismatched++; $display("[TB] FAIL lone_l2_addr: got %0h expected 10000040", l2_addr); end
    compared++; if (arb_busy !== 1'b1) begin mismatched++; $display("[TB] FAIL lone_busy: got %0h expected 1", arb_busy); end
    l2_addrOK = 1; #1;
    compared++; if (icache_addrOK !== 1'b1) begin mismatched++; $display("[TB] FAIL lone_i_addrOK: got %0h expected 1", icache_addrOK); end
    compared++; if (dcache_addrOK !== 1'b0) begin mismatched++; $display("[TB] FAIL lone_d_addrOK: got %0h expected 0", dcache_addrOK); end
    tick();
    l2_addrOK = 0; icache_req = 0; icache_addr = 32'hDEAD_BEEF;
    compared++; if (l2_req !== 1'b0) begin mismatched++; $display("[TB] FAIL lone_l2_req_drop: got %0h expected 0", l2_req); end
    compared++; if (l2_addr !== 32'h1000_0040) begin mismatched++; $display("[TB] FAIL lone_addr_held: got %0h expected 10000040", l2_addr); end
    l2_dataOK = 1; l2_dout = pat; #1;
    compared++; if (icache_dataOK !== 1'b1) begin mismatched++; $display("[TB] FAIL lone_i_dataOK: got %0h expected 1", icache_dataOK); end
    compared++; if (icache_dout !== pat) begin mismatched++; $display("[TB] FAIL lone_i_dout: got %0h expected %0h", icache_dout, pat); end
    compared++; if (dcache_dout !== '0) begin mismatched++; $display("[TB] FAIL lone_d_dout: got %0h expected 0", dcache_dout); end
    compared++; if (dcache_dataOK !== 1'b0) begin mismatched++; $display("[TB] FAIL lone_d_dataOK: got %0h expected 0", dcache_dataOK); end
    tick();
    l2_dataOK = 0;
    compared++; if (arb_busy !== 1'b0) begin mismatched++; $display("[TB] FAIL lone_idle: got %0h expected 0", arb_busy); end
  endtask

  // Both request together: Dcache write wins, Icache follows after the
  // Dcache completes; the Icache transaction then completes with addrOK and
  // dataOK in the same cycle, and a new grant lands right after.
  task automatic test_contention();
    icache_req = 1; icache_addr = 32'h2000_0100;
    dcache_req = 1; dcache_wr = 1; dcache_addr = 32'h3000_0008;
    dcache_din = 32'h1234_5678; dcache_wstrb = 4'b0011;
    tick();
    compared++; if (l2_from !== 2'd3) begin mismatched++; $display("[TB] FAIL cont_from: got %0h expected 3", l2_from); end
    compared++; if (l2_wstrb !== 4'b0011) begin mismatched++; $display("[TB] FAIL cont_wstrb: got %0h expected 3", l2_wstrb); end
    compared++; if (l2_addr !== 32'h3000_0008) begin mismatched++; $display("[TB] FAIL cont_addr: got %0h expected 30000008", l2_addr); end
    compared++; if (l2_din !== 32'h1234_5678) begin mismatched++; $display("[TB] FAIL cont_din: got %0h expected 12345678", l2_din); end
    l2_addrOK = 1; #1;
    compared++; if (dcache_addrOK !== 1'b1) begin mismatched++; $display("[TB] FAIL cont_d_addrOK: got %0h expected 1", dcache_addrOK); end
    compared++; if (icache_addrOK !== 1'b0) begin mismatched++; $display("[TB] FAIL cont_i_addrOK: got %0h expected 0", icache_addrOK); end
    tick();
    l2_addrOK = 0; dcache_req = 0; dcache_wr = 0; dcache_wstrb = 4'b0000;
    l2_dataOK = 1; l2_dout = {4{32'h0F0F_0F0F}}; #1;
    compared++; if (dcache_dataOK !== 1'b1) begin mismatched++; $display("[TB] FAIL cont_d_dataOK: got %0h expected 1", dcache_dataOK); end
    compared++; if (icache_dataOK !== 1'b0) begin mismatched++; $display("[TB] FAIL cont_i_dataOK: got %0h expected 0", icache_dataOK); end
    compared++; if (icache_dout !== '0) begin mismatched++; $display("[TB] FAIL cont_i_dout: got %0h expected 0", icache_dout); end
    tick();
    l2_dataOK = 0;
    compared++; if (l2_req !== 1'b0) begin mismatched++; $display("[TB] FAIL cont_no_early_grant: got %0h expected 0", l2_req); end
    tick();
    compared++; if (l2_req !== 1'b1) begin mismatched++; $display("[TB] FAIL cont_i_grant_req: got %0h expected 1", l2_req); end
    compared++; if (l2_from !== 2'd1) begin mismatched++; $display("[TB] FAIL cont_i_grant_from: got %0h expected 1", l2_from); end
    compared++; if (l2_wstrb !== 4'b0000) begin mismatched++; $display("[TB] FAIL cont_i_wstrb: got %0h expected 0", l2_wstrb); end
    l2_addrOK = 1; l2_dataOK = 1; l2_dout = {4{32'h5A5A_5A5A}}; #1;
    compared++; if (icache_addrOK !== 1'b1) begin mismatched++; $display("[TB] FAIL same_addrOK: got %0h expected 1", icache_addrOK); end
    compared++; if (icache_dataOK !== 1'b1) begin mismatched++; $display("[TB] FAIL same_dataOK: got %0h expected 1", icache_dataOK); end
    tick();
    l2_addrOK = 0; l2_dataOK = 0; icache_req = 0;
    compared++; if (arb_busy !== 1'b0) begin mismatched++; $display("[TB] FAIL same_idle: got %0h expected 0", arb_busy); end
    dcache_req = 1; dcache_wr = 0; dcache_addr = 32'h4000_0000;
    tick();
    compared++; if (l2_req !== 1'b1) begin mismatched++; $display("[TB] FAIL same_next_grant: got %0h expected 1", l2_req); end
    compared++; if (l2_from !== 2'd2) begin mismatched++; $display("[TB] FAIL same_next_from: got %0h expected 2", l2_from); end
    compared++; if (l2_wstrb !== 4'b0000) begin mismatched++; $display("[TB] FAIL read_wstrb: got %0h expected 0", l2_wstrb); end
    l2_addrOK = 1; l2_dataOK = 1;
    tick();
    l2_addrOK = 0; l2_dataOK = 0; dcache_req = 0;
    tick();
  endtask

  // Dcache keeps requesting while the Icache waits: four Dcache grants, then
  // the Icache, then the Dcache again because the count restarted.
  task automatic test_starvation();
    logic       got;
    logic [1:0] exp;
    icache_req = 1; icache_addr = 32'h5000_0000;
    dcache_req = 1; dcache_wr = 0; dcache_addr = 32'h6000_0000;
    for (int k = 0; k < 6; k++) begin
      got = 1'b0;
      for (int w = 0; w < 4 && !got; w++) begin
        tick();
        if (l2_req === 1'b1) got = 1'b1;
      end
      compared++;
      if (!got) begin
        mismatched++; $display("[TB] FAIL starve_wait_%0d: got no l2_req expected l2_req=1", k);
      end else begin
        exp = (k == 4) ? 2'd1 : 2'd2;
        compared++; if (l2_from !== exp) begin mismatched++; $display("[TB] FAIL starve_grant_%0d: got from=%0d expected %0d", k, l2_from, exp); end
        l2_addrOK = 1;
        tick();
        l2_addrOK = 0; l2_dataOK = 1;
        if (k == 5) begin icache_req = 0; dcache_req = 0; end
        tick();
        l2_dataOK = 0;
      end
    end
    icache_req = 0; dcache_req = 0;
    tick();
  endtask

  // Withheld data: timeout after exactly 8 WAIT_DATA cycles, sticky past dataOK.
  task automatic test_watchdog();
    logic [DW-1:0] pat;
    pat = {4{32'hC3C3_3C3C}};
    dcache_req = 1; dcache_wr = 0; dcache_addr = 32'h7000_0010;
    tick();
    l2_addrOK = 1;
    tick();
    l2_addrOK = 0; dcache_req = 0;
    compared++; if (arb_timeout !== 1'b0) begin mismatched++; $display("[TB] FAIL wd_start: got %0h expected 0", arb_timeout); end
    repeat (7) tick();
    compared++; if (arb_timeout !== 1'b0) begin mismatched++; $display("[TB] FAIL wd_7cyc: got %0h expected 0", arb_timeout); end
    tick();
    compared++; if (arb_timeout !== 1'b1) begin mismatched++; $display("[TB] FAIL wd_8cyc: got %0h expected 1", arb_timeout); end
    compared++; if (arb_busy !== 1'b1) begin mismatched++; $display("[TB] FAIL wd_busy: got %0h expected 1", arb_busy); end
    l2_dataOK = 1; l2_dout = pat; #1;
    compared++; if (dcache_dout !== pat) begin mismatched++; $display("[TB] FAIL wd_d_dout: got %0h expected %0h", dcache_dout, pat); end
    tick();
    l2_dataOK = 0;
    compared++; if (arb_timeout !== 1'b1) begin mismatched++; $display("[TB] FAIL wd_sticky: got %0h expected 1", arb_timeout); end
    compared++; if (arb_busy !== 1'b0) begin mismatched++; $display("[TB] FAIL wd_idle: got %0h expected 0", arb_busy); end
  endtask

  // Reset in the middle of WAIT_DATA; later stray L2 handshakes are ignored.
  task automatic test_reset_mid();
    icache_req = 1; icache_addr = 32'h8000_0020;
    tick();
    compared++; if (l2_req !== 1'b1) begin mismatched++; $display("[TB] FAIL rm_grant: got %0h expected 1", l2_req); end
    l2_addrOK = 1;
    tick();
    l2_addrOK = 0; icache_req = 0;
    #2 rst = 1'b1; #1;
    compared++; if (l2_req !== 1'b0) begin mismatched++; $display("[TB] FAIL rm_l2_req: got %0h expected 0", l2_req); end
    compared++; if (l2_from !== 2'd0) begin mismatched++; $display("[TB] FAIL rm_l2_from: got %0h expected 0", l2_from); end
    compared++; if (l2_addr !== 32'h0) begin mismatched++; $display("[TB] FAIL rm_l2_addr: got %0h expected 0", l2_addr); end
    compared++; if (arb_busy !== 1'b0) begin mismatched++; $display("[TB] FAIL rm_busy: got %0h expected 0", arb_busy); end
    compared++; if (arb_timeout !== 1'b0) begin mismatched++; $display("[TB] FAIL rm_timeout: got %0h expected 0", arb_timeout); end
    tick();
    rst = 1'b0;
    tick();
    l2_dataOK = 1; l2_addrOK = 1; l2_dout = {4{32'hFFFF_0000}}; #1;
    compared++; if (icache_dataOK !== 1'b0) begin mismatched++; $display("[TB] FAIL rm_i_dataOK: got %0h expected 0", icache_dataOK); end
    compared++; if (icache_addrOK !== 1'b0) begin mismatched++; $display("[TB] FAIL rm_i_addrOK: got %0h expected 0", icache_addrOK); end
    compared++; if (icache_dout !== '0) begin mismatched++; $display("[TB] FAIL rm_i_dout: got %0h expected 0", icache_dout); end
    tick();
    l2_dataOK = 0; l2_addrOK = 0;
    compared++; if (arb_busy !== 1'b0) begin mismatched++; $display("[TB] FAIL rm_stray_idle: got %0h expected 0", arb_busy); end
  endtask

  initial begin
    test_reset();
    test_lone_icache();
    test_contention();
    test_starvation();
    test_watchdog();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/l2cache_l1_arbiter.md
Name: l2cache_l1_arbiter

Overview:
- Shares the single L1-facing request port of the L2 cache between the Icache and the Dcache.
- Default priority is Dcache-first. A starvation counter guarantees Icache progress.
- Registers the granted request, holds it stable until the L2 accepts it, and routes addrOK, dataOK and read data back to the owner only.
- Sits between the two L1 caches and the L2 cache. Allows one outstanding transaction at a time.

Parameters:
- L1offset_width, 2, log2 of words per L1 line; data width is 32*(1<<L1offset_width).
- STARVE_LIMIT, 4, consecutive Dcache grants allowed while the Icache is waiting.
- TIMEOUT, 1023, maximum cycles in WAIT_DATA before the error flag sets.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: asynchronous, active-high.
- icache_req  in  1  Icache request; held until addrOK.
- icache_addr  in  32  Icache address.
- icache_addrOK  out  1  one-cycle pulse: Icache request accepted by L2.
- icache_dataOK  out  1  one-cycle pulse: icache_dout valid.
- icache_dout  out  32*(1<<L1offset_width)  line to Icache.
- dcache_req  in  1  Dcache request; held until addrOK.
- dcache_wr  in  1  0 = read, 1 = write.
- dcache_addr  in  32  Dcache address.
- dcache_din  in  32  write word.
- dcache_wstrb  in  4  byte strobes.
- dcache_addrOK  out  1  pulse: Dcache request accepted by L2.
- dcache_dataOK  out  1  pulse: read data valid, or write complete.
- dcache_dout  out  32*(1<<L1offset_width)  line to Dcache.
- l2_req  out  1  request to L2.
- l2_from  out  2  source code: 1 = I, 2 = Dr, 3 = Dw.
- l2_addr  out  32  latched address.
- l2_din  out  32  latched write word.
- l2_wstrb  out  4  latched strobes; 0 for reads.
- l2_addrOK  in  1  L2 accepted l2_req.
- l2_dataOK  in  1  L2 response valid.
- l2_dout  in  32*(1<<L1offset_width)  L2 line data.
- arb_busy  out  1  state != IDLE.
- arb_timeout  out  1  sticky error flag.

Behaviour:
- Reset (async, rst=1):
  - state = IDLE, owner = 0, starve_cnt = 0, wd_cnt = 0.
  - All outputs are 0: l2_req, l2_from, l2_addr, l2_din, l2_wstrb, both addrOK, both dataOK, arb_busy, arb_timeout.
  - Reset mid-transaction abandons it silently; no dataOK is issued afterwards.
- States:
  - IDLE → REQ when any request is present.
  - REQ → WAIT_DATA on l2_addrOK.
  - REQ → IDLE on l2_addrOK and l2_dataOK in the same cycle.
  - WAIT_DATA → IDLE on l2_dataOK.
- Grant, evaluated only in IDLE:
  - If icache_req and starve_cnt == STARVE_LIMIT, the Icache wins.
  - Otherwise dcache_req wins, then icache_req.
- Starve counter:
  - On a Dcache grant with icache_req high: starve_cnt increments, saturating at STARVE_LIMIT.
  - On any Icache grant, or a Dcache grant with icache_req low: starve_cnt clears.
- Grant action:
  - Latch owner, addr, din, wstrb and l2_from.
  - Go to REQ; l2_req is high from the next cycle, so latency is 1 cycle from req to l2_req.
  - Latched fields stay constant until the return to IDLE, even if the requester drops or changes its inputs. The request is committed.
- addrOK routing: in REQ, l2_addrOK produces a one-cycle addrOK pulse to the owner only, in the same cycle (combinational). l2_req drops the next cycle.
- dataOK routing: l2_dataOK produces a same-cycle dataOK to the owner. l2_dout is forwarded to the owner's dout; the non-owner's dout holds 0.
- Stray inputs:
  - l2_dataOK in IDLE is ignored.
  - l2_addrOK outside REQ is ignored.
- Simultaneous completion and new request: l2_dataOK and a new request in the same cycle take a single cycle. The completion returns the block to IDLE; the new grant happens in the following cycle. Grant occurs only in IDLE.
- Watchdog:
  - wd_cnt counts cycles in WAIT_DATA and clears on leaving WAIT_DATA.
  - When wd_cnt reaches TIMEOUT, arb_timeout sets and stays set until reset. State is unaffected.
- Requester side: requesters must hold req until their addrOK. A request seen but not granted is not lost; it is re-evaluated in the next IDLE.

Decomposition:
- Shared package l2cache_pkg holds:
  - the source codes FROM_NONE=0, FROM_I=1, FROM_DR=2, FROM_DW=3;
  - the state encoding IDLE/REQ/WAIT_DATA.
- One sub-module, l2cache_arb_prio: the combinational priority/starvation grant plus the starve_cnt register.

Test Plan:
- Reset: rst pulsed mid-WAIT_DATA → all outputs 0 the same cycle. A later l2_dataOK gives no L1 dataOK.
- Lone Icache read: icache_req, addr=0x1000_0040 → next cycle l2_req=1, l2_from=1, l2_addr=0x1000_0040. l2_addrOK → icache_addrOK pulse. l2_dataOK with l2_dout=0xA5.. → icache_dataOK and icache_dout=0xA5..; dcache_dout=0.
- Contention: both requests in the same cycle, dcache_wr=1, wstrb=4'b0011 → Dcache is granted with l2_from=3 and l2_wstrb=3. The Icache is granted after the Dcache's dataOK.
- Starvation: dcache_req held continuously with icache_req high → 4 Dcache grants, then the 5th grant goes to the Icache. starve_cnt is then 0 and the Dcache wins next.
- Same-cycle addrOK+dataOK in REQ → both pulses to the owner, IDLE next cycle, a new grant possible the cycle after.
- Watchdog: with TIMEOUT=8, withhold l2_dataOK → arb_timeout=1 after 8 WAIT_DATA cycles. It stays 1 after a later dataOK and clears only on rst.
